// File: rtl/snap_capture_ctrl_if.sv
// Snapshot BRAM port A write-side bundle: the capture controller drives it,
// the BRAM (or a bench) observes it.
interface snap_capture_ctrl_if #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 9
);
  logic              bram_we;
  logic              bram_en_a;
  logic [AWIDTH-1:0] bram_addr;
  logic [DWIDTH-1:0] bram_wr_data;

  modport master (
    output bram_we,
    output bram_en_a,
    output bram_addr,
    output bram_wr_data
  );

  modport slave (
    input bram_we,
    input bram_en_a,
    input bram_addr,
    input bram_wr_data
  );
endinterface

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture sequencer: arms on a software edge, then writes qualified
// samples into BRAM port A in one-shot (fixed length) or circular mode.
module snap_capture_ctrl #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_valid,
  input  logic              trig,
  input  logic              stop,
  input  logic              ctrl_arm,
  input  logic              ctrl_trig_sel,
  input  logic              ctrl_circ,
  input  logic [AWIDTH:0]   ctrl_len,
  snap_capture_ctrl_if.master bram,
  output logic              status_done,
  output logic              status_busy,
  output logic              status_wrapped,
  output logic [AWIDTH-1:0] status_last_addr
);

  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic              arm_q;
  logic              arm_edge;
  logic [AWIDTH:0]   cnt;
  logic [AWIDTH:0]   cnt_inc;
  logic [AWIDTH:0]   cnt_next;
  logic [AWIDTH:0]   len_q;
  logic [AWIDTH:0]   len_eff;
  logic [AWIDTH-1:0] addr;
  logic              wr;
  logic              final_wr;
  logic              wrap;
  logic              busy_d;
  logic              done_d;

  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;

  assign arm_edge = ctrl_arm & ~arm_q;
  assign addr     = cnt[AWIDTH-1:0];

  always_comb begin
    len_eff  = ((ctrl_len == '0) || (ctrl_len > DEPTH)) ? DEPTH : ctrl_len;
    cnt_inc  = cnt + (AWIDTH+1)'(1);
    // A restart edge wins over a sample arriving in the same cycle.
    wr       = din_valid & ~arm_edge &
               ((state == CAPTURE) ||
                ((state == ARMED) && ctrl_trig_sel && trig));
    final_wr = wr & ~ctrl_circ & (cnt_inc == len_q);
    wrap     = wr & ctrl_circ & (addr == '1);
    cnt_next = ctrl_circ ? {1'b0, addr + AWIDTH'(1)} : cnt_inc;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      arm_q <= 1'b0;
    end else begin
      state <= state_next;
      arm_q <= ctrl_arm;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (arm_edge) state_next = ARMED;
      end
      ARMED: begin
        if (arm_edge)            state_next = ARMED;
        else if (!ctrl_trig_sel) state_next = CAPTURE;
        else if (trig)           state_next = final_wr ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (arm_edge)                            state_next = ARMED;
        else if (ctrl_circ ? stop : final_wr)    state_next = DONE;
      end
      DONE: begin
        if (arm_edge) state_next = ARMED;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags lag the state by one register so done follows the final write.
  always_comb begin
    busy_d = arm_edge || (state == ARMED) || (state == CAPTURE);
    done_d = (state == DONE) && !arm_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      len_q            <= '0;
      status_wrapped   <= 1'b0;
      status_last_addr <= '0;
      status_done      <= 1'b0;
      status_busy      <= 1'b0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      data_q           <= '0;
    end else begin
      status_done <= done_d;
      status_busy <= busy_d;
      we_q        <= wr;
      if (wr) begin
        addr_q <= addr;
        data_q <= din;
      end
      if (arm_edge) begin
        cnt              <= '0;
        len_q            <= len_eff;
        status_wrapped   <= 1'b0;
        status_last_addr <= '0;
      end else if (wr) begin
        cnt              <= cnt_next;
        status_last_addr <= addr;
        if (wrap) status_wrapped <= 1'b1;
      end
    end
  end

  assign bram.bram_we      = we_q;
  assign bram.bram_en_a    = we_q;
  assign bram.bram_addr    = addr_q;
  assign bram.bram_wr_data = data_q;

endmodule
